// File: rtl/perceptron_pkg.sv
// Shared types, defaults and helpers for the perceptron training controller.
// The saturating adder keeps weight updates inside the signed DW range.
package perceptron_pkg;

    localparam int PKG_DW    = 8;
    localparam int PKG_DIM   = 2;
    localparam int PKG_ACC_W = 2*PKG_DW + $clog2(PKG_DIM) + 1;

    localparam logic [1:0] SEL_X = 2'd0;
    localparam logic [1:0] SEL_W = 2'd1;
    localparam logic [1:0] SEL_Y = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC  = 3'd1,
        ST_ACT  = 3'd2,
        ST_UPD  = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic signed [PKG_DW+1:0] SAT_HI = {3'b000, {(PKG_DW-1){1'b1}}};
    localparam logic signed [PKG_DW+1:0] SAT_LO = {3'b111, {(PKG_DW-1){1'b0}}};

    // a + b (or a - b when sub) computed two bits wider so -(-2^(DW-1)) cannot wrap
    function automatic logic [PKG_DW-1:0] sat_add(
        input logic [PKG_DW-1:0] a,
        input logic [PKG_DW-1:0] b,
        input logic              sub
    );
        logic signed [PKG_DW+1:0] ext_a;
        logic signed [PKG_DW+1:0] ext_b;
        logic signed [PKG_DW+1:0] sum;
        logic [PKG_DW-1:0]        res;
        ext_a = $signed({{2{a[PKG_DW-1]}}, a});
        ext_b = $signed({{2{b[PKG_DW-1]}}, b});
        if (sub) begin
            sum = ext_a - ext_b;
        end else begin
            sum = ext_a + ext_b;
        end
        if (sum > SAT_HI) begin
            res = {1'b0, {(PKG_DW-1){1'b1}}};
        end else if (sum < SAT_LO) begin
            res = {1'b1, {(PKG_DW-1){1'b0}}};
        end else begin
            res = sum[PKG_DW-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Signed DW x DW multiply-accumulate with synchronous clear; shared across
// every sample and dimension of the training sequence.
module perceptron_mac
    import perceptron_pkg::*;
#(
    parameter int DW    = PKG_DW,
    parameter int ACC_W = PKG_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DW-1:0]    i_a,
    input  logic [DW-1:0]    i_b,
    output logic [ACC_W-1:0] o_acc
);

    logic signed [2*DW-1:0] w_prod;
    logic [ACC_W-1:0]       w_prod_ext;
    logic [ACC_W-1:0]       r_acc;

    assign w_prod     = $signed(i_a) * $signed(i_b);
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};

    // accumulator register; clear has priority over accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Perceptron training sequencer: holds X/Y/W locally and runs online
// perceptron updates epoch by epoch on a single shared MAC.
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_SAMPLES  = 3,
    parameter int DIM        = 2,
    parameter int DW         = PKG_DW,
    parameter int MAX_EPOCHS = 15,
    parameter int ACC_W      = 2*DW + $clog2(DIM) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [1:0]                     cfg_sel,
    input  logic [7:0]                     cfg_addr,
    input  logic [DW-1:0]                  cfg_wdata,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           converged,
    output logic [3:0]                     epoch_cnt,
    output logic [$clog2(N_SAMPLES+1)-1:0] err_cnt,
    output logic [N_SAMPLES-1:0]           act_vec,
    input  logic [$clog2(DIM)-1:0]         w_rd_idx,
    output logic [DW-1:0]                  w_rd_data
);

    localparam int EW   = $clog2(N_SAMPLES+1);
    localparam int IW   = $clog2(DIM);
    localparam int SW   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int NX   = N_SAMPLES * DIM;
    localparam int XI_W = (NX > 1) ? $clog2(NX) : 1;

    localparam logic [SW-1:0] S_LAST = SW'(N_SAMPLES - 1);
    localparam logic [IW-1:0] D_LAST = IW'(DIM - 1);
    localparam logic [3:0]    EP_MAX = 4'(MAX_EPOCHS);

    state_t r_state;
    state_t w_next;

    logic [DW-1:0]        r_x [NX];
    logic [DW-1:0]        r_w [DIM];
    logic [N_SAMPLES-1:0] r_y;
    logic [SW-1:0]        r_s;
    logic [IW-1:0]        r_d;
    logic [EW-1:0]        r_err_ep;
    logic [EW-1:0]        r_err_out;
    logic [3:0]           r_epoch;
    logic [N_SAMPLES-1:0] r_act;
    logic                 r_delta_neg;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_conv;

    logic                 w_idle;
    logic                 w_start_ok;
    logic                 w_cfg_ok;
    logic                 w_clr;
    logic                 w_mac_en;
    logic [XI_W-1:0]      w_xi;
    logic [DW-1:0]        w_x_cur;
    logic [ACC_W-1:0]     w_acc;
    logic                 w_a;
    logic                 w_delta_nz;
    logic [3:0]           w_epoch_inc;
    logic                 w_busy_cur;
    logic                 w_busy_nxt;

    assign w_idle      = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && !r_busy;
    assign w_start_ok  = start && w_idle;
    assign w_cfg_ok    = cfg_we && w_idle;
    assign w_xi        = XI_W'(32'(r_s) * DIM + 32'(r_d));
    assign w_x_cur     = r_x[w_xi];
    assign w_a         = !w_acc[ACC_W-1] && (w_acc != '0);
    assign w_delta_nz  = (w_a != r_y[r_s]);
    assign w_epoch_inc = r_epoch + 4'd1;

    perceptron_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (w_mac_en),
        .i_a   (w_x_cur),
        .i_b   (r_w[r_d]),
        .o_acc (w_acc)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state decode and MAC control strobes
    always_comb begin
        w_next   = r_state;
        w_clr    = 1'b0;
        w_mac_en = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_next = ST_MAC;
                    w_clr  = 1'b1;
                end else begin
                    w_next = r_state;
                end
            end
            ST_MAC: begin
                w_mac_en = 1'b1;
                w_next   = (r_d == D_LAST) ? ST_ACT : ST_MAC;
            end
            ST_ACT: begin
                w_next = w_delta_nz ? ST_UPD : ST_NEXT;
            end
            ST_UPD: begin
                w_next = (r_d == D_LAST) ? ST_NEXT : ST_UPD;
            end
            ST_NEXT: begin
                if (r_s != S_LAST) begin
                    w_next = ST_MAC;
                    w_clr  = 1'b1;
                end else if (r_err_ep == '0) begin
                    w_next = ST_DONE;
                end else if (w_epoch_inc == EP_MAX) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_MAC;
                    w_clr  = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // busy spans the start handoff through the first DONE cycle
    assign w_busy_cur = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_busy_nxt = (w_next != ST_IDLE) && (w_next != ST_DONE);

    // status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_cur || w_busy_nxt;
            r_done <= (r_state == ST_DONE) && (w_next == ST_DONE);
        end
    end

    // configuration writes, sequencing counters and weight updates
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NX; i++) begin
                r_x[i] <= '0;
            end
            for (int i = 0; i < DIM; i++) begin
                r_w[i] <= '0;
            end
            r_y         <= '0;
            r_s         <= '0;
            r_d         <= '0;
            r_err_ep    <= '0;
            r_err_out   <= '0;
            r_epoch     <= 4'd0;
            r_act       <= '0;
            r_delta_neg <= 1'b0;
            r_conv      <= 1'b0;
        end else begin
            if (w_cfg_ok) begin
                case (cfg_sel)
                    SEL_X: if (cfg_addr < 8'(NX)) r_x[XI_W'(cfg_addr)] <= cfg_wdata;
                    SEL_W: if (cfg_addr < 8'(DIM)) r_w[IW'(cfg_addr)] <= cfg_wdata;
                    SEL_Y: if (cfg_addr < 8'(N_SAMPLES)) r_y[SW'(cfg_addr)] <= cfg_wdata[0];
                    default: ;
                endcase
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_s      <= '0;
                        r_d      <= '0;
                        r_err_ep <= '0;
                        r_epoch  <= 4'd0;
                        r_conv   <= 1'b0;
                    end
                end
                ST_MAC: begin
                    r_d <= (r_d == D_LAST) ? '0 : r_d + 1'b1;
                end
                ST_ACT: begin
                    r_act[r_s]  <= w_a;
                    r_delta_neg <= w_a;
                    if (w_delta_nz) begin
                        r_err_ep <= r_err_ep + 1'b1;
                    end
                end
                ST_UPD: begin
                    r_w[r_d] <= sat_add(r_w[r_d], w_x_cur, r_delta_neg);
                    r_d      <= (r_d == D_LAST) ? '0 : r_d + 1'b1;
                end
                ST_NEXT: begin
                    if (r_s != S_LAST) begin
                        r_s <= r_s + 1'b1;
                    end else begin
                        r_err_out <= r_err_ep;
                        r_epoch   <= w_epoch_inc;
                        r_conv    <= (r_err_ep == '0);
                        if (w_next == ST_MAC) begin
                            r_s      <= '0;
                            r_err_ep <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign converged = r_conv;
    assign epoch_cnt = r_epoch;
    assign err_cnt   = r_err_out;
    assign act_vec   = r_act;
    assign w_rd_data = r_w[w_rd_idx];

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed bench: two controller instances (default and single-epoch limit)
// share the config bus; expected values are hand-computed training traces.
module tb_perceptron_train_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       start_a;
    logic       start_b;
    logic       rd_idx;

    logic       busy_a, done_a, conv_a;
    logic [3:0] epoch_a;
    logic [1:0] err_a;
    logic [2:0] act_a;
    logic [7:0] rd_a;

    logic       busy_b, done_b, conv_b;
    logic [3:0] epoch_b;
    logic [1:0] err_b;
    logic [2:0] act_b;
    logic [7:0] rd_b;

    int n_tests = 0;
    int n_fail  = 0;

    perceptron_train_ctrl u_dut_a (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .start(start_a),
        .busy(busy_a), .done(done_a), .converged(conv_a), .epoch_cnt(epoch_a),
        .err_cnt(err_a), .act_vec(act_a), .w_rd_idx(rd_idx), .w_rd_data(rd_a)
    );

    perceptron_train_ctrl #(.MAX_EPOCHS(1)) u_dut_b (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .start(start_b),
        .busy(busy_b), .done(done_b), .converged(conv_b), .epoch_cnt(epoch_b),
        .err_cnt(err_b), .act_vec(act_b), .w_rd_idx(rd_idx), .w_rd_data(rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [7:0] addr, input logic [7:0] data);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    // x0..x5 in sample-major order, then w0,w1 and y0..y2
    task automatic load_all(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2,
                            input logic [7:0] x3, input logic [7:0] x4, input logic [7:0] x5,
                            input logic [7:0] w0, input logic [7:0] w1,
                            input logic y0, input logic y1, input logic y2);
        cfg_write(2'd0, 8'd0, x0);
        cfg_write(2'd0, 8'd1, x1);
        cfg_write(2'd0, 8'd2, x2);
        cfg_write(2'd0, 8'd3, x3);
        cfg_write(2'd0, 8'd4, x4);
        cfg_write(2'd0, 8'd5, x5);
        cfg_write(2'd1, 8'd0, w0);
        cfg_write(2'd1, 8'd1, w1);
        cfg_write(2'd2, 8'd0, {7'd0, y0});
        cfg_write(2'd2, 8'd1, {7'd0, y1});
        cfg_write(2'd2, 8'd2, {7'd0, y2});
    endtask

    task automatic wait_done_b(input int budget);
        for (int i = 0; i < budget && !done_b; i++) begin
            tick();
        end
        check_eq("b_done_timeout", {31'd0, done_b}, 32'd1);
    endtask

    initial begin
        int busy_cycles;
        int done_rises;
        logic prev_done;

        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_addr = 8'd0; cfg_wdata = 8'd0;
        start_a = 1'b0; start_b = 1'b0; rd_idx = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        check_eq("rst_busy",  {31'd0, busy_a}, 32'd0);
        check_eq("rst_done",  {31'd0, done_a}, 32'd0);
        check_eq("rst_conv",  {31'd0, conv_a}, 32'd0);
        check_eq("rst_epoch", {28'd0, epoch_a}, 32'd0);
        check_eq("rst_err",   {30'd0, err_a}, 32'd0);
        check_eq("rst_act",   {29'd0, act_a}, 32'd0);
        check_eq("rst_w0",    {24'd0, rd_a}, 32'd0);

        // converge scenario, plus dropped reserved/out-of-range writes
        load_all(8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        cfg_write(2'd1, 8'd2, 8'd77);
        cfg_write(2'd3, 8'd0, 8'd55);
        rd_idx = 1'b0; #1;
        check_eq("drop_w0", {24'd0, rd_a}, 32'd0);
        rd_idx = 1'b1; #1;
        check_eq("drop_w1", {24'd0, rd_a}, 32'd0);

        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 200 && busy_a; i++) begin
            busy_cycles++;
            tick();
        end
        check_eq("conv_busy_cycles", busy_cycles, 32'd27);
        check_eq("conv_done",  {31'd0, done_a}, 32'd1);
        check_eq("conv_conv",  {31'd0, conv_a}, 32'd1);
        check_eq("conv_epoch", {28'd0, epoch_a}, 32'd2);
        check_eq("conv_err",   {30'd0, err_a}, 32'd0);
        check_eq("conv_act",   {29'd0, act_a}, 32'b101);
        rd_idx = 1'b0; #1;
        check_eq("conv_w0", {24'd0, rd_a}, 32'd1);
        rd_idx = 1'b1; #1;
        check_eq("conv_w1", {24'd0, rd_a}, 32'd0);

        // busy lockout: restart from W=(1,0), then write and start during MAC
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("lock_done_cleared", {31'd0, done_a}, 32'd0);
        tick();
        start_a = 1'b1;
        cfg_write(2'd1, 8'd0, 8'd50);
        start_a = 1'b0;
        done_rises = 0;
        prev_done = done_a;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done_a && !prev_done) done_rises++;
            prev_done = done_a;
        end
        check_eq("lock_done_rises", done_rises, 32'd1);
        check_eq("lock_conv",  {31'd0, conv_a}, 32'd1);
        check_eq("lock_epoch", {28'd0, epoch_a}, 32'd1);
        rd_idx = 1'b0; #1;
        check_eq("lock_w0", {24'd0, rd_a}, 32'd1);

        // reset while in UPD of sample 0: start, MAC, MAC, ACT, UPD
        cfg_write(2'd1, 8'd0, 8'd0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_busy",  {31'd0, busy_a}, 32'd0);
        check_eq("mrst_done",  {31'd0, done_a}, 32'd0);
        check_eq("mrst_epoch", {28'd0, epoch_a}, 32'd0);
        rd_idx = 1'b0; #1;
        check_eq("mrst_w0", {24'd0, rd_a}, 32'd0);
        rd_idx = 1'b1; #1;
        check_eq("mrst_w1", {24'd0, rd_a}, 32'd0);

        // epoch limit on the single-epoch instance
        load_all(8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd2, 8'd4, 8'd9, 1'b0, 1'b1, 1'b1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_done_b(100);
        check_eq("lim_conv",  {31'd0, conv_b}, 32'd0);
        check_eq("lim_epoch", {28'd0, epoch_b}, 32'd1);
        check_eq("lim_err",   {30'd0, err_b}, 32'd1);
        check_eq("lim_act",   {29'd0, act_b}, 32'b111);
        rd_idx = 1'b0; #1;
        check_eq("lim_w0", {24'd0, rd_b}, 32'd2);
        rd_idx = 1'b1; #1;
        check_eq("lim_w1", {24'd0, rd_b}, 32'd6);

        // saturation: only sample 0 is live, W=(127,-128)
        load_all(8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_done_b(100);
        check_eq("sat_conv", {31'd0, conv_b}, 32'd0);
        check_eq("sat_err",  {30'd0, err_b}, 32'd1);
        check_eq("sat_act",  {29'd0, act_b}, 32'b000);
        rd_idx = 1'b0; #1;
        check_eq("sat_w0", {24'd0, rd_b}, 32'h7F);
        rd_idx = 1'b1; #1;
        check_eq("sat_w1", {24'd0, rd_b}, 32'h81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
